// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, launch-FSM
// state encoding and the transmitter-accept timeout.
package uart_tx_feeder_pkg;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int TMO_W        = 3;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [TMO_W-1:0]  tmo_t;

  // Last count value spent in WAIT_BUSY before giving up on the transmitter.
  localparam tmo_t TMO_LAST = tmo_t'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_WAIT_BUSY = 3'b010,
    ST_WAIT_DONE = 3'b100
  } launch_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers; full/empty/level come
// straight from the registered pointers.
module uart_sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define what is valid,
  // and leaving it out keeps the array mappable onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one frame at a time into the UART
// transmitter's start/data/ready interface.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  output logic          o_ready,
  output logic          o_tx_start,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_ready,
  output logic [AW:0]   o_level,
  output logic          o_empty,
  output logic          o_overflow
);

  logic          full;
  logic          empty;
  logic          launch;
  byte_t         head_data;
  launch_state_e state;
  launch_state_e state_n;
  tmo_t          tmo_cnt;
  tmo_t          tmo_cnt_n;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (launch),
    .pop_data  (head_data),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  // A push that lands on a full FIFO is dropped; the pointers do not move.
  assign o_ready    = !full;
  assign o_empty    = empty;
  assign o_overflow = i_valid && full;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    tmo_cnt_n = tmo_cnt;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && i_tx_ready) begin
          launch    = 1'b1;
          tmo_cnt_n = '0;
          state_n   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // A transmitter that never drops ready is treated as having sent the byte.
        if (!i_tx_ready) begin
          state_n = ST_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = ST_IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      state      <= state_n;
      tmo_cnt    <= tmo_cnt_n;
      o_tx_start <= launch;
      if (launch) o_tx_data <= head_data;
    end
  end

endmodule
